// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared definitions for the memory-mapped countdown timer.
//   - FSM state encoding (IDLE/LOAD/CNT/INT as 0..3)
//   - register word offsets seen on Addr[3:2]
//   - CTRL bit positions and mode codes
//   - mode_of(): folds the reserved mode codes (1x) onto one-shot
package timer_dev_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCnt  = 2'd2,
        StInt  = 2'd3
    } timer_state_e;

    // Register word offsets
    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    // CTRL field positions; bus bits above IM_BIT read as 0
    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned MODE_LSB = 1;
    localparam int unsigned MODE_MSB = 2;
    localparam int unsigned IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Effective operating mode: only 01 selects auto-reload, 00 and 1x run one-shot.
    function automatic logic [1:0] mode_of(input logic [CTRL_W-1:0] ctrl);
        if (ctrl[MODE_MSB:MODE_LSB] == MODE_RELOAD) begin
            return MODE_RELOAD;
        end
        return MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// timer_dev: countdown timer responding on the CPU peripheral bridge.
//
// Registers (word offset on Addr):
//   0 CTRL   : [0] Enable, [2:1] Mode (01 reload, else one-shot), [3] IM
//   1 PRESET : reload value, CNT_W bits
//   2 COUNT  : current count, read-only
//   3        : reserved, reads 0, writes ignored
//
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   Addr  : word offset from the bridge
//   WE    : write strobe, already qualified by the bridge's device select
//   Din   : write data
//   Dout  : read data, combinational from Addr, no read side effects
//   IRQ   : interrupt request, irq flag gated by CTRL.IM
//
// Operation: IDLE -> LOAD (COUNT <= PRESET) -> CNT (decrement until COUNT <= 1)
// -> INT (flag raised). One-shot clears Enable and holds the flag until the CPU
// writes CTRL or PRESET; reload drops the flag after one cycle and restarts, giving
// a period of PRESET+3 cycles.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int unsigned      CNT_W      = 32,
    parameter logic [CNT_W-1:0] RST_PRESET = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  preset_q;
    logic [CNT_W-1:0]  count_q;
    logic              irq_flag_q;
    timer_state_e      state_q;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = WE && (Addr == CTRL_OFF);
    assign wr_preset = WE && (Addr == PRESET_OFF);

    // Several sources can update the same register on one edge. The statements
    // below are ordered so that the later non-blocking assignment carries the
    // intended priority:
    //   - a CPU write clears the flag, but a flag set by CNT on the same edge wins;
    //   - the INT-state Enable clear is overridden by a CPU write to CTRL.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= RST_PRESET;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= StIdle;
        end else begin
            if (wr_ctrl || wr_preset) begin
                irq_flag_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (ctrl_q[EN_BIT]) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    // Uses the PRESET value from before any write on this same edge.
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!ctrl_q[EN_BIT]) begin
                        // Disabled mid-count: COUNT freezes where it is.
                        state_q <= StIdle;
                    end else if (count_q <= CNT_W'(1)) begin
                        // Covers PRESET=0 as well; COUNT saturates at 0.
                        count_q    <= '0;
                        irq_flag_q <= 1'b1;
                        state_q    <= StInt;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                StInt: begin
                    if (mode_of(ctrl_q) == MODE_ONESHOT) begin
                        ctrl_q[EN_BIT] <= 1'b0;
                    end else begin
                        irq_flag_q <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (wr_ctrl) begin
                ctrl_q <= Din[CTRL_W-1:0];
            end
            if (wr_preset) begin
                preset_q <= Din[CNT_W-1:0];
            end
        end
    end

    // Read mux; registers narrower than the bus are zero-extended.
    always_comb begin
        Dout = '0;
        unique case (Addr)
            CTRL_OFF:   Dout[CTRL_W-1:0] = ctrl_q;
            PRESET_OFF: Dout[CNT_W-1:0]  = preset_q;
            COUNT_OFF:  Dout[CNT_W-1:0]  = count_q;
            default:    Dout = '0;
        endcase
    end

    // Both terms are flops, so IRQ carries no decode glitches.
    assign IRQ = irq_flag_q & ctrl_q[IM_BIT];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed stimulus, an abstract per-edge model
// compared on every negedge, and hand-computed literal checks.
module tb_timer_dev;

    localparam logic [31:0] RST_P = 32'h0000_1234;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    timer_dev #(
        .CNT_W      (32),
        .RST_PRESET (RST_P)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // Run phases: 0 off, 1 armed (load next edge), 2 running, 3 expired.
    // While running, COUNT is derived from the number of edges since the load.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;
    longint      m_n;
    longint      m_load_edge;
    longint      edge_no = 0;

    task automatic model_edge();
        logic [3:0] c;
        logic       f;
        logic       set_now;
        longint     el;
        longint     lim;
        if (reset) begin
            m_ctrl   = 4'h0;
            m_preset = RST_P;
            m_count  = 32'h0;
            m_flag   = 1'b0;
            m_phase  = 0;
        end else begin
            c       = m_ctrl;
            f       = m_flag;
            set_now = 1'b0;
            case (m_phase)
                0: if (m_ctrl[0]) m_phase = 1;
                1: begin
                    m_n         = longint'(m_preset);
                    m_load_edge = edge_no;
                    m_count     = m_preset;
                    m_phase     = 2;
                end
                2: begin
                    if (!m_ctrl[0]) begin
                        m_phase = 0;
                    end else begin
                        el  = edge_no - m_load_edge;
                        lim = (m_n == 0) ? 1 : m_n;
                        if (el >= lim) begin
                            m_count = 32'h0;
                            f       = 1'b1;
                            set_now = 1'b1;
                            m_phase = 3;
                        end else begin
                            m_count = 32'(m_n - el);
                        end
                    end
                end
                default: begin
                    if (m_ctrl[2:1] == 2'b01) f = 1'b0;
                    else c[0] = 1'b0;
                    m_phase = 0;
                end
            endcase
            if (WE && Addr == 2'd0) c = Din[3:0];
            if (WE && Addr == 2'd1) m_preset = Din;
            if (WE && (Addr == 2'd0 || Addr == 2'd1) && !set_now) f = 1'b0;
            m_ctrl = c;
            m_flag = f;
        end
    endtask

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        edge_no++;
        model_edge();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%h expected 0x%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dout", Dout, model_dout(Addr));
            check("model_irq", {31'h0, IRQ}, {31'h0, m_flag & m_ctrl[3]});
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 1ns after a rising edge; the default read address is COUNT.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        WE   = 1'b1;
        Din  = d;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Din  = 32'h0;
        Addr = 2'd2;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(name, Dout, exp);
        Addr = 2'd2;
    endtask

    task automatic irq_check(input string name, input logic exp);
        check(name, {31'h0, IRQ}, {31'h0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 2'd2;
        Din   = 32'h0;
        idle(2);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset values and ignored writes
        rd_check("rst_ctrl", 2'd0, 32'h0);
        rd_check("rst_preset", 2'd1, RST_P);
        rd_check("rst_count", 2'd2, 32'h0);
        rd_check("rst_rsvd", 2'd3, 32'h0);
        irq_check("rst_irq", 1'b0);
        wr(2'd2, 32'h55);
        rd_check("count_ro", 2'd2, 32'h0);
        wr(2'd3, 32'hDEAD_BEEF);
        rd_check("rsvd_ro", 2'd3, 32'h0);
        wr(2'd0, 32'hFFFF_FFF0);
        rd_check("ctrl_upper_ignored", 2'd0, 32'h0);

        // Mode 0: PRESET=5, enable at edge t
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        idle(1);
        rd_check("m0_load_cycle", 2'd2, 32'h0);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            rd_check("m0_count", 2'd2, 32'(5 - k));
            irq_check("m0_irq_edge", k == 5);
        end
        idle(3);
        irq_check("m0_irq_held", 1'b1);
        rd_check("m0_en_cleared", 2'd0, 32'h8);
        wr(2'd0, 32'h8);
        irq_check("m0_irq_cleared", 1'b0);
        idle(2);
        irq_check("m0_irq_stays_low", 1'b0);

        // Mode 1: PRESET=3 gives a 6-cycle period
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            idle(1);
            irq_check("m1_irq_pulse", (k >= 5) && ((k - 5) % 6 == 0));
            if (k >= 2 && (k - 2) % 6 == 0) rd_check("m1_reload", 2'd2, 32'd3);
        end
        wr(2'd0, 32'h0);
        idle(5);

        // Masked one-shot
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            irq_check("mask_irq_low", 1'b0);
        end
        rd_check("mask_en_cleared", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        irq_check("mask_flag_cleared", 1'b0);
        idle(2);
        irq_check("mask_flag_cleared2", 1'b0);

        // PRESET write mid-count, then disable
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        idle(6);
        rd_check("mid_count6", 2'd2, 32'd6);
        wr(2'd1, 32'd2);
        rd_check("mid_no_reload", 2'd2, 32'd5);
        idle(2);
        rd_check("mid_count3", 2'd2, 32'd3);
        wr(2'd0, 32'h0);
        idle(3);
        rd_check("mid_frozen", 2'd2, 32'd2);
        irq_check("mid_no_irq", 1'b0);

        // Flag set by CNT beats a same-edge PRESET write; CTRL write beats Enable clear
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        idle(2);
        wr(2'd1, 32'd1);
        irq_check("set_beats_clear", 1'b1);
        wr(2'd0, 32'h9);
        rd_check("cpu_ctrl_wins", 2'd0, 32'h9);
        irq_check("cpu_ctrl_clears_flag", 1'b0);
        wr(2'd0, 32'h0);
        idle(5);

        // Reset mid-count
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        idle(5);
        rd_check("pre_reset_count", 2'd2, 32'd7);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rd_check("post_reset_ctrl", 2'd0, 32'h0);
        rd_check("post_reset_preset", 2'd1, RST_P);
        rd_check("post_reset_count", 2'd2, 32'h0);
        irq_check("post_reset_irq", 1'b0);
        idle(4);
        rd_check("post_reset_idle", 2'd2, 32'h0);

        idle(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
